bd_upstream_arbiter: RTL and testbench
======================================

BD_UPSTREAM_ARBITER -- requirements
Module: bd_upstream_arbiter

Interface
REQ-001 Parameter NPayload, default 32: payload width of both sources.
REQ-002 Parameter NCode, default 4: leaf/code width of both sources.
REQ-003 Parameter MaxBurst, default 8: maximum consecutive BD grants while the FPGA source waits.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 dec_in_v  in  1  decoded BD word valid.
REQ-007 dec_in_leaf_code  in  NCode  leaf code (0-12 valid leaves, 13 = INVALID).
REQ-008 dec_in_payload  in  NPayload  decoded BD payload.
REQ-009 dec_in_a  out  1  BD word accepted this cycle.
REQ-010 fpga_in_v  in  1  FPGA-generated word valid.
REQ-011 fpga_in_code  in  NCode  FPGA word code.
REQ-012 fpga_in_payload  in  NPayload  FPGA word payload.
REQ-013 fpga_in_a  out  1  FPGA word accepted this cycle.
REQ-014 out_v  out  1  upstream word valid (registered).
REQ-015 out_d  out  1+NCode+NPayload  {src, code, payload}; src=1 for BD, 0 for FPGA (registered).
REQ-016 out_a  in  1  upstream consumer accepts out_d this cycle.
REQ-017 drop_count  out  16  count of INVALID BD words discarded (registered).

Function
REQ-018 A transfer on any channel occurs in a cycle where its v and a are both high.
REQ-019 The output slot is free when out_v=0 or out_a=1.
REQ-020 BD word with leaf code 13 is acked (dec_in_a=1) in the same cycle it is valid, independent of slot state, is never loaded, and increments drop_count.
REQ-021 drop_count saturates at 0xFFFF.
REQ-022 Urgent: a valid BD word with code 9 or 10 (OVFLW0/1) is granted whenever the slot is free, regardless of the burst counter.
REQ-023 Otherwise BD has priority over FPGA when the slot is free, except when burst_cnt = MaxBurst and fpga_in_v=1, in which case FPGA is granted.
REQ-024 burst_cnt increments on each BD grant while fpga_in_v=1, saturating at MaxBurst.
REQ-025 burst_cnt clears on an FPGA grant and in any cycle fpga_in_v=0.
REQ-026 Acks are combinational: dec_in_a = BD grant or drop; fpga_in_a = FPGA grant; at most one grant per cycle.
REQ-027 On a grant, out_d loads {src, code, payload} and out_v=1 on the next edge: latency 1 cycle.
REQ-028 On a free slot with no grant, out_v goes to 0 on the next edge.
REQ-029 out_d and out_v are held stable while out_v=1 and out_a=0.
REQ-030 Output acceptance and a new load in the same cycle give back-to-back words: throughput 1 word/cycle.
REQ-031 Inputs are not acked (except drops) while the slot is not free.

Reset
REQ-032 While reset=1: out_v=0, out_d=0, burst_cnt=0, drop_count=0, dec_in_a=0, fpga_in_a=0.
REQ-033 Reset asserted mid-operation discards any held output word; no input is acked in a reset cycle, including INVALID words.
REQ-034 First grant is possible in the first cycle after reset deasserts.

Verification
REQ-035 BD code 3/payload 0x12345678, out_a=1 -> dec_in_a same cycle; next cycle out_v=1, out_d={1,3,0x12345678}.
REQ-036 Both sources valid continuously, out_a=1, MaxBurst=8 -> 8 BD words, then 1 FPGA word, repeating.
REQ-037 burst_cnt=8, fpga_in_v=1, BD code 9 valid -> BD OVFLW granted; FPGA granted next free cycle.
REQ-038 out_a=0 for 5 cycles with out_v=1 -> out_d unchanged, no grants; INVALID BD words still acked, drop_count +1 each.
REQ-039 drop_count=0xFFFF plus one INVALID word -> stays 0xFFFF; reset while out_v=1 -> out_v=0, drop_count=0 next cycle.

Source files
------------

// File: rtl/bd_upstream_arbiter.sv
// Upstream arbiter: merges decoded BD words and FPGA-generated words into a single
// registered output slot. BD has priority, bounded by a burst limit while the FPGA
// source waits; overflow leaves bypass the limit and INVALID leaves are dropped
// and counted.
module bd_upstream_arbiter #(
    parameter int unsigned NPayload = 32,
    parameter int unsigned NCode    = 4,
    parameter int unsigned MaxBurst = 8
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       dec_in_v,
    input  logic [NCode-1:0]           dec_in_leaf_code,
    input  logic [NPayload-1:0]        dec_in_payload,
    output logic                       dec_in_a,

    input  logic                       fpga_in_v,
    input  logic [NCode-1:0]           fpga_in_code,
    input  logic [NPayload-1:0]        fpga_in_payload,
    output logic                       fpga_in_a,

    output logic                       out_v,
    output logic [NCode+NPayload:0]    out_d,
    input  logic                       out_a,

    output logic [15:0]                drop_count
);

    localparam int unsigned OutW   = 1 + NCode + NPayload;
    localparam int unsigned BurstW = (MaxBurst < 1) ? 1 : $clog2(MaxBurst + 1);

    localparam logic [BurstW-1:0] BurstMax    = BurstW'(MaxBurst);
    localparam logic [NCode-1:0]  CodeInvalid = NCode'(13);
    localparam logic [NCode-1:0]  CodeOvflw0  = NCode'(9);
    localparam logic [NCode-1:0]  CodeOvflw1  = NCode'(10);
    localparam logic [15:0]       DropMax     = 16'hFFFF;

    // State
    logic                r_out_v;
    logic [OutW-1:0]     r_out_d;
    logic [BurstW-1:0]   r_burst_cnt;
    logic [15:0]         r_drop_count;

    // Next state
    logic                w_out_v_nxt;
    logic [OutW-1:0]     w_out_d_nxt;
    logic [BurstW-1:0]   w_burst_cnt_nxt;
    logic [15:0]         w_drop_count_nxt;

    // Arbitration terms
    logic                w_slot_free;
    logic                w_bd_drop;
    logic                w_bd_word;
    logic                w_bd_urgent;
    logic                w_fpga_turn;
    logic                w_grant_bd;
    logic                w_grant_fpga;

    // Decode the incoming BD word and pick at most one winner for the output slot.
    always_comb begin
        w_slot_free  = 1'b0;
        w_bd_drop    = 1'b0;
        w_bd_word    = 1'b0;
        w_bd_urgent  = 1'b0;
        w_fpga_turn  = 1'b0;
        w_grant_bd   = 1'b0;
        w_grant_fpga = 1'b0;

        w_slot_free = ~r_out_v | out_a;
        w_bd_drop   = dec_in_v & (dec_in_leaf_code == CodeInvalid);
        w_bd_word   = dec_in_v & (dec_in_leaf_code != CodeInvalid);
        w_bd_urgent = w_bd_word &
                      ((dec_in_leaf_code == CodeOvflw0) | (dec_in_leaf_code == CodeOvflw1));
        // FPGA has waited out a full BD burst and now gets one slot.
        w_fpga_turn = fpga_in_v & (r_burst_cnt == BurstMax);

        // Nothing is accepted in a reset cycle, not even drops.
        if (!reset && w_slot_free) begin
            if (w_bd_word && (w_bd_urgent || !w_fpga_turn)) begin
                w_grant_bd = 1'b1;
            end else if (fpga_in_v) begin
                w_grant_fpga = 1'b1;
            end
        end
        if (reset) begin
            w_bd_drop = 1'b0;
        end
    end

    // Acks are combinational; a drop acks the BD word regardless of the slot.
    always_comb begin
        dec_in_a  = w_grant_bd | w_bd_drop;
        fpga_in_a = w_grant_fpga;
    end

    // Output slot, burst counter and drop counter next-state.
    always_comb begin
        w_out_v_nxt      = r_out_v;
        w_out_d_nxt      = r_out_d;
        w_burst_cnt_nxt  = r_burst_cnt;
        w_drop_count_nxt = r_drop_count;

        if (w_grant_bd) begin
            w_out_v_nxt = 1'b1;
            w_out_d_nxt = {1'b1, dec_in_leaf_code, dec_in_payload};
        end else if (w_grant_fpga) begin
            w_out_v_nxt = 1'b1;
            w_out_d_nxt = {1'b0, fpga_in_code, fpga_in_payload};
        end else if (w_slot_free) begin
            // Word consumed (or slot already empty) and nothing to replace it.
            w_out_v_nxt = 1'b0;
        end

        // Burst only counts BD wins that actually made the FPGA source wait.
        if (!fpga_in_v || w_grant_fpga) begin
            w_burst_cnt_nxt = '0;
        end else if (w_grant_bd && (r_burst_cnt != BurstMax)) begin
            w_burst_cnt_nxt = r_burst_cnt + 1'b1;
        end

        if (w_bd_drop && (r_drop_count != DropMax)) begin
            w_drop_count_nxt = r_drop_count + 16'd1;
        end
    end

    // State registers with synchronous reset; reset discards any held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_v      <= 1'b0;
            r_out_d      <= '0;
            r_burst_cnt  <= '0;
            r_drop_count <= '0;
        end else begin
            r_out_v      <= w_out_v_nxt;
            r_out_d      <= w_out_d_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_drop_count <= w_drop_count_nxt;
        end
    end

    // Registered outputs.
    always_comb begin
        out_v      = r_out_v;
        out_d      = r_out_d;
        drop_count = r_drop_count;
    end

endmodule

// File: tb/tb_bd_upstream_arbiter.sv
// Self-checking bench for bd_upstream_arbiter: directed vector table, hand-written
// multi-cycle sequences (burst fairness, overflow bypass, drop saturation, reset)
// and a randomized run against a behavioural model.
module tb_bd_upstream_arbiter;

    localparam int NP = 32;
    localparam int NC = 4;
    localparam int MB = 8;
    localparam int OW = 1 + NC + NP;

    logic           clk;
    logic           reset;
    logic           dec_in_v;
    logic [NC-1:0]  dec_in_leaf_code;
    logic [NP-1:0]  dec_in_payload;
    logic           dec_in_a;
    logic           fpga_in_v;
    logic [NC-1:0]  fpga_in_code;
    logic [NP-1:0]  fpga_in_payload;
    logic           fpga_in_a;
    logic           out_v;
    logic [OW-1:0]  out_d;
    logic           out_a;
    logic [15:0]    drop_count;

    bd_upstream_arbiter #(
        .NPayload (NP),
        .NCode    (NC),
        .MaxBurst (MB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .dec_in_v         (dec_in_v),
        .dec_in_leaf_code (dec_in_leaf_code),
        .dec_in_payload   (dec_in_payload),
        .dec_in_a         (dec_in_a),
        .fpga_in_v        (fpga_in_v),
        .fpga_in_code     (fpga_in_code),
        .fpga_in_payload  (fpga_in_payload),
        .fpga_in_a        (fpga_in_a),
        .out_v            (out_v),
        .out_d            (out_d),
        .out_a            (out_a),
        .drop_count       (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Behavioural model: one held word, an integer wait counter and drop tally.
    bit             m_ov    = 1'b0;
    logic [OW-1:0]  m_od    = '0;
    int             m_burst = 0;
    int             m_drop  = 0;
    bit             m_bdw, m_fpw, m_inv, m_free;

    typedef struct {
        bit           rst;
        bit           dv;
        logic [3:0]   dc;
        logic [31:0]  dp;
        bit           fv;
        logic [3:0]   fc;
        logic [31:0]  fp;
        bit           oa;
        bit           eda;
        bit           efa;
        bit           eov;
        bit           chkd;
        logic [OW-1:0] eod;
        logic [15:0]  edc;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(bit rst, bit dv, int dc, logic [31:0] dp, bit fv, int fc,
                                logic [31:0] fp, bit oa, bit eda, bit efa, bit eov,
                                bit chkd, bit esrc, int ecode, logic [31:0] epay, int edc);
        vec_t v;
        v.rst = rst; v.dv = dv; v.dc = 4'(dc); v.dp = dp;
        v.fv = fv; v.fc = 4'(fc); v.fp = fp; v.oa = oa;
        v.eda = eda; v.efa = efa; v.eov = eov; v.chkd = chkd;
        v.eod = {esrc, 4'(ecode), epay};
        v.edc = 16'(edc);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %h want %h", name, cyc, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input bit rst, input bit dv, input logic [3:0] dc,
                         input logic [31:0] dp, input bit fv, input logic [3:0] fc,
                         input logic [31:0] fp, input bit oa);
        @(negedge clk);
        cyc++;
        reset = rst; dec_in_v = dv; dec_in_leaf_code = dc; dec_in_payload = dp;
        fpga_in_v = fv; fpga_in_code = fc; fpga_in_payload = fp; out_a = oa;
        #1;
        model_eval();
    endtask

    // Decide who the rules say wins this cycle, from model state and live inputs.
    task automatic model_eval();
        bit ok, urg, fpga_waited_out;
        m_bdw = 0; m_fpw = 0; m_inv = 0; m_free = 0;
        if (!reset) begin
            m_free = !m_ov || out_a;
            m_inv  = dec_in_v && (dec_in_leaf_code == 4'd13);
            ok     = dec_in_v && !m_inv;
            urg    = ok && (dec_in_leaf_code == 4'd9 || dec_in_leaf_code == 4'd10);
            fpga_waited_out = fpga_in_v && (m_burst >= MB);
            if (m_free && ok && (urg || !fpga_waited_out)) m_bdw = 1;
            else if (m_free && fpga_in_v) m_fpw = 1;
        end
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_commit();
        if (reset) begin
            m_ov = 0; m_od = '0; m_burst = 0; m_drop = 0;
        end else begin
            if (m_inv && m_drop < 65535) m_drop++;
            if (m_bdw) begin
                m_ov = 1; m_od = {1'b1, dec_in_leaf_code, dec_in_payload};
            end else if (m_fpw) begin
                m_ov = 1; m_od = {1'b0, fpga_in_code, fpga_in_payload};
            end else if (m_free) begin
                m_ov = 0;
            end
            if (!fpga_in_v || m_fpw) m_burst = 0;
            else if (m_bdw) m_burst = (m_burst + 1 > MB) ? MB : m_burst + 1;
        end
    endtask

    task automatic model_check();
        check("dec_in_a", 64'(dec_in_a), 64'(m_bdw || m_inv));
        check("fpga_in_a", 64'(fpga_in_a), 64'(m_fpw));
        check("out_v", 64'(out_v), 64'(m_ov));
        if (m_ov) check("out_d", 64'(out_d), 64'(m_od));
        check("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic idle_cycle(input bit rst, input bit oa);
        drive(rst, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, oa);
        model_commit();
    endtask

    initial begin
        reset = 1; dec_in_v = 0; dec_in_leaf_code = '0; dec_in_payload = '0;
        fpga_in_v = 0; fpga_in_code = '0; fpga_in_payload = '0; out_a = 0;

        // ---------------- Directed vector table ----------------
        //          rst dv dc  dp            fv fc fp            oa  da fa ov cd src code pay        dc
        vecs[0]  = mk(1, 1, 13, 32'h0,        1, 1, 32'h11,       1,  0, 0, 0, 1, 0, 0,  32'h0,        0);
        vecs[1]  = mk(0, 1, 3,  32'h12345678, 0, 0, 32'h0,        1,  1, 0, 0, 1, 0, 0,  32'h0,        0);
        vecs[2]  = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        1,  0, 0, 1, 1, 1, 3,  32'h12345678, 0);
        vecs[3]  = mk(0, 1, 13, 32'hDEAD,     1, 5, 32'hAAAA0001, 1,  1, 1, 0, 0, 0, 0,  32'h0,        0);
        vecs[4]  = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        0,  0, 0, 1, 1, 0, 5,  32'hAAAA0001, 1);
        vecs[5]  = mk(0, 1, 4,  32'h44,       1, 6, 32'h66,       0,  0, 0, 1, 1, 0, 5,  32'hAAAA0001, 1);
        vecs[6]  = mk(0, 1, 13, 32'h0,        1, 6, 32'h66,       0,  1, 0, 1, 1, 0, 5,  32'hAAAA0001, 1);
        vecs[7]  = mk(0, 1, 13, 32'h0,        0, 0, 32'h0,        0,  1, 0, 1, 1, 0, 5,  32'hAAAA0001, 2);
        vecs[8]  = mk(0, 1, 2,  32'h22,       1, 7, 32'h77,       1,  1, 0, 1, 1, 0, 5,  32'hAAAA0001, 3);
        vecs[9]  = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        0,  0, 0, 1, 1, 1, 2,  32'h22,       3);
        vecs[10] = mk(1, 1, 13, 32'h0,        1, 7, 32'h77,       0,  0, 0, 1, 1, 1, 2,  32'h22,       3);
        vecs[11] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        0,  0, 0, 0, 1, 0, 0,  32'h0,        0);
        vecs[12] = mk(0, 1, 10, 32'h0BADF00D, 1, 8, 32'h88,       0,  1, 0, 0, 0, 0, 0,  32'h0,        0);
        vecs[13] = mk(0, 0, 0,  32'h0,        0, 0, 32'h0,        1,  0, 0, 1, 1, 1, 10, 32'h0BADF00D, 0);

        idle_cycle(1, 0);
        idle_cycle(1, 0);
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].dv, vecs[i].dc, vecs[i].dp,
                  vecs[i].fv, vecs[i].fc, vecs[i].fp, vecs[i].oa);
            check($sformatf("vec%0d.dec_in_a", i), 64'(dec_in_a), 64'(vecs[i].eda));
            check($sformatf("vec%0d.fpga_in_a", i), 64'(fpga_in_a), 64'(vecs[i].efa));
            check($sformatf("vec%0d.out_v", i), 64'(out_v), 64'(vecs[i].eov));
            if (vecs[i].chkd)
                check($sformatf("vec%0d.out_d", i), 64'(out_d), 64'(vecs[i].eod));
            check($sformatf("vec%0d.drop_count", i), 64'(drop_count), 64'(vecs[i].edc));
            model_commit();
        end

        // ---------------- Burst fairness: 8 BD then 1 FPGA ----------------
        idle_cycle(1, 1);
        idle_cycle(0, 1);
        for (int i = 0; i < 27; i++) begin
            drive(0, 1, 4'd1, 32'(i), 1, 4'd2, 32'(1000 + i), 1);
            check("burst.fpga_in_a", 64'(fpga_in_a), 64'((i % 9) == 8));
            check("burst.dec_in_a", 64'(dec_in_a), 64'((i % 9) != 8));
            model_commit();
        end

        // ---------------- Overflow leaf bypasses the burst limit ----------------
        idle_cycle(0, 1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 4'd1, 32'h0, 1, 4'd2, 32'h0, 1);
            model_commit();
        end
        drive(0, 1, 4'd9, 32'hCAFE0009, 1, 4'd2, 32'h0F0F, 1);
        check("ovflw.dec_in_a", 64'(dec_in_a), 64'd1);
        check("ovflw.fpga_in_a", 64'(fpga_in_a), 64'd0);
        model_commit();
        drive(0, 1, 4'd1, 32'h1, 1, 4'd2, 32'h0F0F, 1);
        check("ovflw.out_d", 64'(out_d), 64'({1'b1, 4'd9, 32'hCAFE0009}));
        check("after_ovflw.fpga_in_a", 64'(fpga_in_a), 64'd1);
        check("after_ovflw.dec_in_a", 64'(dec_in_a), 64'd0);
        model_commit();

        // ---------------- Drop counter saturation, then reset with word held ----------------
        idle_cycle(1, 1);
        for (int i = 0; i < 65535; i++) begin
            drive(0, 1, 4'd13, 32'h0, 0, 4'd0, 32'h0, 1);
            model_commit();
        end
        drive(0, 1, 4'd13, 32'h0, 0, 4'd0, 32'h0, 1);
        check("sat.drop_count_full", 64'(drop_count), 64'hFFFF);
        check("sat.dec_in_a", 64'(dec_in_a), 64'd1);
        model_commit();
        drive(0, 1, 4'd5, 32'h55, 0, 4'd0, 32'h0, 1);
        check("sat.drop_count_held", 64'(drop_count), 64'hFFFF);
        model_commit();
        drive(1, 1, 4'd13, 32'h0, 1, 4'd3, 32'h0, 0);
        check("rst.out_v_before", 64'(out_v), 64'd1);
        check("rst.dec_in_a", 64'(dec_in_a), 64'd0);
        check("rst.fpga_in_a", 64'(fpga_in_a), 64'd0);
        model_commit();
        idle_cycle(0, 0);
        check("rst.out_v_after", 64'(out_v), 64'd0);
        check("rst.out_d_after", 64'(out_d), 64'd0);
        check("rst.drop_count_after", 64'(drop_count), 64'd0);

        // ---------------- Randomized run against the model ----------------
        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [3:0] dc;
            sel = int'($urandom_range(0, 99));
            if (sel < 15)      dc = 4'd13;
            else if (sel < 30) dc = (sel < 22) ? 4'd9 : 4'd10;
            else               dc = 4'($urandom_range(0, 12));
            drive($urandom_range(0, 99) == 0, ($urandom % 4) != 0, dc, $urandom,
                  ($urandom % 3) != 0, 4'($urandom_range(0, 12)), $urandom,
                  ($urandom % 4) != 0);
            model_check();
            model_commit();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
